// File: rtl/pooling_drain.sv
// Serialises completed pooled rows from a two-entry ping-pong buffer into word writes.
// Optional macro POOL_DRAIN_RELU_EN clamps negative output words to zero.
module pooling_drain #(
  parameter int DATA_WIDTH = 16,
  parameter int COL        = 32,
  parameter int ADDR_WIDTH = 12,
  parameter int ROWS_WIDTH = 10
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [ROWS_WIDTH-1:0] num_rows,
  input  logic                  pool_valid,
  input  logic [DATA_WIDTH-1:0] pool_data [COL],
  output logic                  pool_ready,
  output logic                  wr_valid,
  input  logic                  wr_ready,
  output logic [ADDR_WIDTH-1:0] wr_addr,
  output logic [DATA_WIDTH-1:0] wr_data,
  output logic                  busy,
  output logic                  done
);

  localparam int CW = (COL > 1) ? $clog2(COL) : 1;
  localparam logic [CW-1:0] LAST_COL = CW'(COL - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t                state, next_state;
  logic [DATA_WIDTH-1:0] row_buf [2][COL];
  logic [1:0]            occupancy;
  logic                  wr_ptr, rd_ptr;
  logic [CW-1:0]         col_idx;
  logic [ROWS_WIDTH-1:0] rows_target, rows_accepted, rows_drained;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic                  push, pop, row_end, last_row;
  logic [DATA_WIDTH-1:0] sel_data;

  // Readiness uses registered occupancy only, so a full buffer never passes a row through.
  always_comb begin
    pool_ready = (state == RUN) && (occupancy < 2'd2) && (rows_accepted < rows_target);
    wr_valid   = (occupancy != 2'd0);
    push       = pool_valid && pool_ready;
    pop        = wr_valid && wr_ready;
    row_end    = pop && (col_idx == LAST_COL);
    last_row   = (rows_drained + ROWS_WIDTH'(1)) == rows_target;
    sel_data   = wr_valid ? row_buf[rd_ptr][col_idx] : '0;
    wr_addr    = addr_q;
`ifdef POOL_DRAIN_RELU_EN
    wr_data    = sel_data[DATA_WIDTH-1] ? '0 : sel_data;
`else
    wr_data    = sel_data;
`endif
  end

  always_comb begin
    next_state = state;
    busy       = 1'b0;
    done       = 1'b0;
    case (state)
      IDLE: if (start) next_state = (num_rows == '0) ? DONE : RUN;
      RUN: begin
        busy = 1'b1;
        if (row_end && last_row) next_state = DONE;
      end
      DONE: begin
        done       = 1'b1;
        next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      occupancy     <= 2'd0;
      wr_ptr        <= 1'b0;
      rd_ptr        <= 1'b0;
      col_idx       <= '0;
      rows_target   <= '0;
      rows_accepted <= '0;
      rows_drained  <= '0;
      addr_q        <= '0;
    end else begin
      state <= next_state;
      if (state == IDLE && start) begin
        addr_q        <= base_addr;
        rows_target   <= num_rows;
        rows_accepted <= '0;
        rows_drained  <= '0;
        occupancy     <= 2'd0;
        wr_ptr        <= 1'b0;
        rd_ptr        <= 1'b0;
        col_idx       <= '0;
      end else begin
        if (push) begin
          wr_ptr        <= ~wr_ptr;
          rows_accepted <= rows_accepted + ROWS_WIDTH'(1);
        end
        if (pop) begin
          addr_q  <= addr_q + ADDR_WIDTH'(1);
          col_idx <= row_end ? '0 : col_idx + CW'(1);
        end
        if (row_end) begin
          rd_ptr       <= ~rd_ptr;
          rows_drained <= rows_drained + ROWS_WIDTH'(1);
        end
        // A push and a row completion in the same cycle leave occupancy unchanged.
        case ({push, row_end})
          2'b10:   occupancy <= occupancy + 2'd1;
          2'b01:   occupancy <= occupancy - 2'd1;
          default: occupancy <= occupancy;
        endcase
      end
    end
  end

  // Row storage carries no reset; stale contents are never read while occupancy is zero.
  always_ff @(posedge clk) begin
    if (push) begin
      for (int c = 0; c < COL; c++) row_buf[wr_ptr][c] <= pool_data[c];
    end
  end

endmodule

// File: tb/tb_pooling_drain.sv
// Directed self-checking bench for pooling_drain with COL=4.
// Expected values are hand-computed per step; build with POOL_DRAIN_RELU_EN to check the clamp.
module tb_pooling_drain;

  logic        clk;
  logic        rst;
  logic        start;
  logic [11:0] base_addr;
  logic [9:0]  num_rows;
  logic        pool_valid;
  logic [15:0] pool_data [4];
  logic        pool_ready;
  logic        wr_valid;
  logic        wr_ready;
  logic [11:0] wr_addr;
  logic [15:0] wr_data;
  logic        busy;
  logic        done;

  int tests_run;
  int tests_failed;

  logic [15:0] exp1 [4];
  logic [11:0] wrap_addr [4];
  logic [15:0] rows [12];

  pooling_drain #(
    .DATA_WIDTH(16),
    .COL       (4),
    .ADDR_WIDTH(12),
    .ROWS_WIDTH(10)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .base_addr (base_addr),
    .num_rows  (num_rows),
    .pool_valid(pool_valid),
    .pool_data (pool_data),
    .pool_ready(pool_ready),
    .wr_valid  (wr_valid),
    .wr_ready  (wr_ready),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .busy      (busy),
    .done      (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [15:0] relu(input logic [15:0] v);
`ifdef POOL_DRAIN_RELU_EN
    return v[15] ? 16'h0000 : v;
`else
    return v;
`endif
  endfunction

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic applyStimulus(input logic s, input logic [11:0] base, input logic [9:0] nrows);
    start     = s;
    base_addr = base;
    num_rows  = nrows;
  endtask

  task automatic load_row(input logic [15:0] a, input logic [15:0] b,
                          input logic [15:0] c, input logic [15:0] d);
    pool_data[0] = a;
    pool_data[1] = b;
    pool_data[2] = c;
    pool_data[3] = d;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    tests_run++;
    assert (observed === expected)
    else begin
      tests_failed++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
`ifdef POOL_DRAIN_RELU_EN
    exp1 = '{16'd5, 16'h0000, 16'd7, 16'd9};
`else
    exp1 = '{16'd5, 16'hFFFD, 16'd7, 16'd9};
`endif
    wrap_addr = '{12'hFFE, 12'hFFF, 12'h000, 12'h001};
    rows = '{16'd1, 16'd2, 16'd3, 16'd4,
             16'h8000, 16'd6, 16'd7, 16'd8,
             16'd9, 16'd10, 16'hFFF0, 16'd12};

    rst        = 1'b1;
    pool_valid = 1'b0;
    wr_ready   = 1'b0;
    applyStimulus(1'b0, 12'h000, 10'd0);
    load_row(16'd0, 16'd0, 16'd0, 16'd0);
    step();
    step();
    checkOutput("reset_wr_valid", 32'(wr_valid), 32'd0);
    checkOutput("reset_busy", 32'(busy), 32'd0);
    checkOutput("reset_done", 32'(done), 32'd0);
    checkOutput("reset_pool_ready", 32'(pool_ready), 32'd0);
    checkOutput("reset_wr_addr", 32'(wr_addr), 32'd0);
    checkOutput("reset_wr_data", 32'(wr_data), 32'd0);
    rst = 1'b0;
    step();

    // Single row, no back-pressure.
    wr_ready = 1'b1;
    applyStimulus(1'b1, 12'h010, 10'd1);
    step();
    applyStimulus(1'b0, 12'h000, 10'd0);
    checkOutput("t1_busy", 32'(busy), 32'd1);
    checkOutput("t1_pool_ready", 32'(pool_ready), 32'd1);
    checkOutput("t1_no_write_yet", 32'(wr_valid), 32'd0);
    load_row(16'd5, 16'hFFFD, 16'd7, 16'd9);
    pool_valid = 1'b1;
    step();
    pool_valid = 1'b0;
    checkOutput("t1_ready_after_last_row", 32'(pool_ready), 32'd0);
    for (int i = 0; i < 4; i++) begin
      checkOutput("t1_wr_valid", 32'(wr_valid), 32'd1);
      checkOutput("t1_wr_addr", 32'(wr_addr), 32'(12'h010 + 12'(i)));
      checkOutput("t1_wr_data", 32'(wr_data), 32'(exp1[i]));
      checkOutput("t1_busy_during", 32'(busy), 32'd1);
      step();
    end
    checkOutput("t1_done", 32'(done), 32'd1);
    checkOutput("t1_busy_falls", 32'(busy), 32'd0);
    checkOutput("t1_wr_valid_off", 32'(wr_valid), 32'd0);
    step();
    checkOutput("t1_done_one_cycle", 32'(done), 32'd0);

    // Three rows with the output stalled: only two rows fit.
    wr_ready = 1'b0;
    applyStimulus(1'b1, 12'h010, 10'd3);
    step();
    applyStimulus(1'b0, 12'h000, 10'd0);
    load_row(rows[0], rows[1], rows[2], rows[3]);
    pool_valid = 1'b1;
    checkOutput("t2_ready_row0", 32'(pool_ready), 32'd1);
    step();
    load_row(rows[4], rows[5], rows[6], rows[7]);
    checkOutput("t2_ready_row1", 32'(pool_ready), 32'd1);
    checkOutput("t2_stall_valid0", 32'(wr_valid), 32'd1);
    step();
    load_row(rows[8], rows[9], rows[10], rows[11]);
    for (int c = 0; c < 18; c++) begin
      checkOutput("t2_full_not_ready", 32'(pool_ready), 32'd0);
      checkOutput("t2_stall_valid", 32'(wr_valid), 32'd1);
      checkOutput("t2_stall_addr", 32'(wr_addr), 32'h010);
      checkOutput("t2_stall_data", 32'(wr_data), 32'(relu(rows[0])));
      step();
    end
    wr_ready = 1'b1;
    for (int k = 0; k < 12; k++) begin
      checkOutput("t2_wr_valid", 32'(wr_valid), 32'd1);
      checkOutput("t2_wr_addr", 32'(wr_addr), 32'(12'h010 + 12'(k)));
      checkOutput("t2_wr_data", 32'(wr_data), 32'(relu(rows[k])));
      checkOutput("t2_pool_ready", 32'(pool_ready), (k == 4) ? 32'd1 : 32'd0);
      step();
      if (k == 4) pool_valid = 1'b0;
    end
    checkOutput("t2_done", 32'(done), 32'd1);
    step();

    // Address wrap at the top of the buffer.
    applyStimulus(1'b1, 12'hFFE, 10'd1);
    step();
    applyStimulus(1'b0, 12'h000, 10'd0);
    load_row(16'd100, 16'd101, 16'd102, 16'd103);
    pool_valid = 1'b1;
    step();
    pool_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      checkOutput("t3_wr_addr", 32'(wr_addr), 32'(wrap_addr[i]));
      checkOutput("t3_wr_data", 32'(wr_data), 32'(16'd100 + 16'(i)));
      step();
    end
    checkOutput("t3_done", 32'(done), 32'd1);
    step();

    // Empty frame.
    applyStimulus(1'b1, 12'h055, 10'd0);
    step();
    applyStimulus(1'b0, 12'h000, 10'd0);
    pool_valid = 1'b1;
    checkOutput("t4_done", 32'(done), 32'd1);
    checkOutput("t4_busy", 32'(busy), 32'd0);
    checkOutput("t4_wr_valid", 32'(wr_valid), 32'd0);
    checkOutput("t4_pool_ready", 32'(pool_ready), 32'd0);
    step();
    checkOutput("t4_done_clear", 32'(done), 32'd0);
    checkOutput("t4_pool_ready_idle", 32'(pool_ready), 32'd0);
    pool_valid = 1'b0;

    // Reset in the middle of a row discards it.
    applyStimulus(1'b1, 12'h020, 10'd1);
    step();
    applyStimulus(1'b0, 12'h000, 10'd0);
    load_row(16'd11, 16'd12, 16'd13, 16'd14);
    pool_valid = 1'b1;
    step();
    pool_valid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      checkOutput("t5_pre_addr", 32'(wr_addr), 32'(12'h020 + 12'(i)));
      step();
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    checkOutput("t5_rst_wr_valid", 32'(wr_valid), 32'd0);
    checkOutput("t5_rst_busy", 32'(busy), 32'd0);
    checkOutput("t5_rst_wr_addr", 32'(wr_addr), 32'd0);
    step();
    checkOutput("t5_idle_wr_valid", 32'(wr_valid), 32'd0);
    applyStimulus(1'b1, 12'h040, 10'd1);
    step();
    applyStimulus(1'b0, 12'h000, 10'd0);
    checkOutput("t5_empty_after_reset", 32'(wr_valid), 32'd0);
    load_row(16'd21, 16'd22, 16'd23, 16'd24);
    pool_valid = 1'b1;
    step();
    pool_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      checkOutput("t5_wr_valid", 32'(wr_valid), 32'd1);
      checkOutput("t5_wr_addr", 32'(wr_addr), 32'(12'h040 + 12'(i)));
      checkOutput("t5_wr_data", 32'(wr_data), 32'(16'd21 + 16'(i)));
      step();
    end
    checkOutput("t5_done", 32'(done), 32'd1);
    checkOutput("t5_no_extra_write", 32'(wr_valid), 32'd0);
    step();

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
